// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling sequencing controller.
package pool_pkg;

    // Mirrors the ADDR_FIFO width from header.vh.
    localparam int ADDR_FIFO = 10;
    localparam int POOL_WIN  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } pool_state_t;

endpackage

// File: rtl/pool_idx_counter.sv
// Wrapping column/row index pair; column wraps at col_max and carries into row.
module pool_idx_counter
    import pool_pkg::*;
#(
    parameter int DIM_W = ADDR_FIFO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIM_W-1:0] col_max,
    input  logic [DIM_W-1:0] row_max,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] row,
    output logic             last
);

    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;

    assign col  = col_q;
    assign row  = row_q;
    assign last = (col_q == col_max) && (row_q == row_max);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (col_q == col_max) begin
                col_d = '0;
                row_d = (row_q == row_max) ? '0 : row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/pool_ctrl.sv
// Pooling sequencer: frame start/clear, input pacing, 2x2 stride-2 tap marking,
// pipeline drain and completion signalling.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int DIM_W    = ADDR_FIFO,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] row_length,
    input  logic [DIM_W-1:0] num_rows,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shifting_line,
    output logic             line_buffer_reset,
    output logic             pool_enable,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    pool_state_t         state_q, state_d;
    logic [DIM_W-1:0]    row_len_q, row_len_d;
    logic [DIM_W-1:0]    num_rows_q, num_rows_d;
    logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [PIPE_LAT-1:0] valid_pipe_q, valid_pipe_d;
    logic                cfg_err_q, cfg_err_d;

    logic [DIM_W-1:0] col, row;
    logic [DIM_W-1:0] col_max, row_max;
    logic [DIM_W-1:0] tap_col_max, tap_row_max;
    logic             last, accept, cnt_clr, tap, cfg_ok;

    assign in_ready          = (state_q == RUN);
    assign shifting_line     = in_valid & in_ready;
    assign line_buffer_reset = (state_q == CLEAR);
    assign pool_enable       = (state_q == RUN) || (state_q == DRAIN);
    assign busy              = (state_q != IDLE);
    assign out_valid         = valid_pipe_q[PIPE_LAT-1];
    assign cfg_err           = cfg_err_q;

    assign accept  = shifting_line & ~abort;
    assign col_max = row_len_q - DIM_W'(1);
    assign row_max = num_rows_q - DIM_W'(1);

    // Last index of the even-sized region; trailing odd column/row never pools.
    assign tap_col_max = {row_len_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
    assign tap_row_max = {num_rows_q[DIM_W-1:1], 1'b0} - DIM_W'(1);
    assign tap = accept & col[0] & row[0] & (col <= tap_col_max) & (row <= tap_row_max);

    pool_idx_counter #(.DIM_W(DIM_W)) u_idx (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .clr     (cnt_clr),
        .col_max (col_max),
        .row_max (row_max),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    always_comb begin
        state_d     = state_q;
        row_len_d   = row_len_q;
        num_rows_d  = num_rows_q;
        drain_cnt_d = drain_cnt_q;
        cfg_err_d   = 1'b0;
        cnt_clr     = 1'b0;
        done        = 1'b0;
        cfg_ok      = (row_length >= DIM_W'(POOL_WIN)) && (num_rows >= DIM_W'(POOL_WIN));

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        row_len_d  = row_length;
                        num_rows_d = num_rows;
                        cnt_clr    = 1'b1;
                        state_d    = CLEAR;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                if (accept && last) begin
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            row_len_d   = row_len_q;
            num_rows_d  = num_rows_q;
            drain_cnt_d = '0;
            cfg_err_d   = 1'b0;
            cnt_clr     = 1'b1;
            done        = 1'b0;
        end
    end

    always_comb begin
        valid_pipe_d    = '0;
        valid_pipe_d[0] = tap;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            valid_pipe_d[i] = valid_pipe_q[i-1];
        end
        if (abort) begin
            valid_pipe_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            row_len_q    <= '0;
            num_rows_q   <= '0;
            drain_cnt_q  <= '0;
            valid_pipe_q <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_len_q    <= row_len_d;
            num_rows_q   <= num_rows_d;
            drain_cnt_q  <= drain_cnt_d;
            valid_pipe_q <= valid_pipe_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: frame table, random frames, reset/abort corners,
// with a per-cycle timeline reference model.
module tb_pool_ctrl;

    localparam int DIM_W = 8;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst, start, abort, in_valid;
    logic [DIM_W-1:0] row_length, num_rows;
    logic             in_ready, shifting_line, line_buffer_reset, pool_enable;
    logic             out_valid, busy, done, cfg_err;

    int errors = 0;
    int checks = 0;

    pool_ctrl #(.DIM_W(DIM_W), .PIPE_LAT(LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .row_length        (row_length),
        .num_rows          (num_rows),
        .abort             (abort),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .shifting_line     (shifting_line),
        .line_buffer_reset (line_buffer_reset),
        .pool_enable       (pool_enable),
        .out_valid         (out_valid),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    // Timeline model: a frame is described by its CLEAR cycle, pixel count and
    // the cycle of its final accepted pixel; pooled outputs are scheduled cycles.
    int  cyc = 0;
    bit  m_on;
    int  m_clr, m_last, m_pix, m_rl, m_nr, m_cfgerr;
    int  ov_q[$];
    logic s_ov, s_sh, s_done, s_cfg, s_busy, s_lbr;

    typedef struct {
        int rl, nr, pct, abort_at;
        bit mid;
        int outs, shifts, dones, cfgs, lbrs;
    } vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_last = -1; m_pix = 0; m_clr = -10; m_cfgerr = -10;
        ov_q.delete();
    endtask

    task automatic cycle();
        bit e_rdy, e_busy, e_pen, e_done, e_lbr, e_ov, e_cfg;
        int n, r, c;
        @(negedge clk);
        n      = cyc;
        e_lbr  = m_on && (n == m_clr);
        e_rdy  = m_on && (n > m_clr) && (m_last < 0);
        e_busy = m_on && ((m_last < 0) || (n <= m_last + LAT));
        e_pen  = e_busy && (n > m_clr);
        e_done = m_on && (m_last >= 0) && (n == m_last + LAT) && !abort;
        e_ov   = (ov_q.size() > 0) && (ov_q[0] == n);
        e_cfg  = (n == m_cfgerr);
        chk("in_ready", in_ready, e_rdy);
        chk("shifting_line", shifting_line, in_valid & e_rdy);
        chk("line_buffer_reset", line_buffer_reset, e_lbr);
        chk("pool_enable", pool_enable, e_pen);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("out_valid", out_valid, e_ov);
        chk("cfg_err", cfg_err, e_cfg);
        s_ov = out_valid; s_sh = shifting_line; s_done = done;
        s_cfg = cfg_err; s_busy = busy; s_lbr = line_buffer_reset;

        if (e_ov) void'(ov_q.pop_front());
        if (rst) begin
            model_reset();
        end else if (abort) begin
            m_on = 1'b0;
            ov_q.delete();
        end else begin
            if (e_rdy && in_valid) begin
                r = m_pix / m_rl;
                c = m_pix % m_rl;
                if ((r % 2 == 1) && (c % 2 == 1) && (c < 2 * (m_rl / 2)) && (r < 2 * (m_nr / 2)))
                    ov_q.push_back(n + LAT);
                m_pix++;
                if (m_pix == m_rl * m_nr) m_last = n;
            end
            if (m_on && (m_last >= 0) && (n == m_last + LAT)) m_on = 1'b0;
            if (start && !e_busy) begin
                if (row_length >= 2 && num_rows >= 2) begin
                    m_on = 1'b1; m_clr = n + 1; m_pix = 0; m_last = -1;
                    m_rl = int'(row_length); m_nr = int'(num_rows);
                end else begin
                    m_cfgerr = n + 1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_frame(input int rl, input int nr, input int pct, input int abort_at,
                             input bit mid, output int outs, output int shifts,
                             output int dones, output int cfgs, output int lbrs);
        int  budget, after;
        bit  seen_busy, did_abort, did_mid;
        outs = 0; shifts = 0; dones = 0; cfgs = 0; lbrs = 0;
        after = 0; seen_busy = 0; did_abort = 0; did_mid = 0;
        row_length = DIM_W'(rl);
        num_rows   = DIM_W'(nr);
        start      = 1'b1;
        in_valid   = 1'b0;
        cycle();
        start = 1'b0;
        for (budget = 0; budget < 400; budget++) begin
            in_valid = ($urandom_range(99) < pct);
            if (abort_at >= 0 && shifts == abort_at && !did_abort) begin
                abort = 1'b1; in_valid = 1'b0; did_abort = 1'b1;
            end
            if (mid && shifts == 3 && !did_mid) begin
                start = 1'b1; row_length = 1; num_rows = 1; did_mid = 1'b1;
            end
            cycle();
            abort = 1'b0;
            start = 1'b0;
            outs   += int'(s_ov);
            shifts += int'(s_sh);
            dones  += int'(s_done);
            cfgs   += int'(s_cfg);
            lbrs   += int'(s_lbr);
            if (s_busy) seen_busy = 1'b1;
            else after++;
            if (after >= 4 && (seen_busy || budget >= 4)) break;
        end
        in_valid = 1'b0;
        checks++;
        if (budget >= 400) begin
            errors++;
            $display("FAIL frame_end: no return to idle within %0d cycles (%0dx%0d)", budget, rl, nr);
        end
    endtask

    initial begin
        vec_t tbl[11];
        int outs, shifts, dones, cfgs, lbrs, rl, nr;

        tbl[0]  = '{4, 4, 100, -1, 1'b0, 4, 16, 1, 0, 1};
        tbl[1]  = '{5, 3, 100, -1, 1'b0, 2, 15, 1, 0, 1};
        tbl[2]  = '{4, 4,  50, -1, 1'b0, 4, 16, 1, 0, 1};
        tbl[3]  = '{1, 4, 100, -1, 1'b0, 0,  0, 0, 1, 0};
        tbl[4]  = '{4, 0, 100, -1, 1'b0, 0,  0, 0, 1, 0};
        tbl[5]  = '{4, 4, 100,  6, 1'b0, 0,  6, 0, 0, 1};
        tbl[6]  = '{4, 4, 100, -1, 1'b0, 4, 16, 1, 0, 1};
        tbl[7]  = '{4, 4,  60, -1, 1'b1, 4, 16, 1, 0, 1};
        tbl[8]  = '{2, 2, 100, -1, 1'b0, 1,  4, 1, 0, 1};
        tbl[9]  = '{7, 5,  70, -1, 1'b0, 6, 35, 1, 0, 1};
        tbl[10] = '{3, 2,  40, -1, 1'b0, 1,  6, 1, 0, 1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        row_length = '0; num_rows = '0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        foreach (tbl[i]) begin
            run_frame(tbl[i].rl, tbl[i].nr, tbl[i].pct, tbl[i].abort_at, tbl[i].mid,
                      outs, shifts, dones, cfgs, lbrs);
            chk_int($sformatf("vec%0d outs", i), outs, tbl[i].outs);
            chk_int($sformatf("vec%0d shifts", i), shifts, tbl[i].shifts);
            chk_int($sformatf("vec%0d dones", i), dones, tbl[i].dones);
            chk_int($sformatf("vec%0d cfg_err", i), cfgs, tbl[i].cfgs);
            chk_int($sformatf("vec%0d lbr", i), lbrs, tbl[i].lbrs);
        end

        for (int k = 0; k < 6; k++) begin
            rl = int'($urandom_range(9, 2));
            nr = int'($urandom_range(6, 2));
            run_frame(rl, nr, int'($urandom_range(100, 20)), -1, 1'b0,
                      outs, shifts, dones, cfgs, lbrs);
            chk_int($sformatf("rand%0d outs", k), outs, (rl / 2) * (nr / 2));
            chk_int($sformatf("rand%0d shifts", k), shifts, rl * nr);
            chk_int($sformatf("rand%0d dones", k), dones, 1);
        end

        // Asynchronous reset while draining.
        row_length = 4; num_rows = 4; start = 1'b1; in_valid = 1'b0;
        cycle();
        start = 1'b0; in_valid = 1'b1; shifts = 0;
        for (int b = 0; b < 40 && shifts < 16; b++) begin
            cycle();
            shifts += int'(s_sh);
        end
        chk_int("rst_seq shifts", shifts, 16);
        chk("rst_seq in_drain", pool_enable && !in_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async busy", busy, 1'b0);
        chk("rst_async pool_enable", pool_enable, 1'b0);
        chk("rst_async in_ready", in_ready, 1'b0);
        chk("rst_async shifting_line", shifting_line, 1'b0);
        chk("rst_async out_valid", out_valid, 1'b0);
        chk("rst_async done", done, 1'b0);
        chk("rst_async line_buffer_reset", line_buffer_reset, 1'b0);
        chk("rst_async cfg_err", cfg_err, 1'b0);
        model_reset();
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        run_frame(4, 4, 100, -1, 1'b0, outs, shifts, dones, cfgs, lbrs);
        chk_int("post_rst outs", outs, 4);
        chk_int("post_rst lbr", lbrs, 1);
        chk_int("post_rst dones", dones, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
